// File: rtl/tdc_ctl_pkg.sv
// Shared constants and types for the TDC control register slave:
// register offsets, field bit positions, response codes and decode result.
package tdc_ctl_pkg;

  localparam logic [31:0] ID_VALUE_DEF = 32'h7DC0_0100;

  localparam int CH_BASE   = 'h10;
  localparam int CH_STRIDE = 'h10;
  localparam int CH_SHIFT  = 4;

  localparam logic [1:0] ADDR_ID     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd1;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVF     = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_CFG    = 2'd1,
    REG_STATUS = 2'd2,
    REG_RESULT = 2'd3
  } ch_reg_e;

  typedef enum logic [1:0] {
    TGT_NONE   = 2'd0,
    TGT_ID     = 2'd1,
    TGT_IRQ_EN = 2'd2,
    TGT_CH     = 2'd3
  } tgt_e;

  typedef struct packed {
    tgt_e     tgt;
    logic [2:0] ch;
    ch_reg_e  sel;
  } dec_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tdc_ch_regs.sv
// Per-channel register slice: enable/start control, config word,
// sticky done/overflow status and the captured result.
module tdc_ch_regs
  import tdc_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_ctrl,
  input  logic        wr_cfg,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        done_in,
  input  logic [31:0] result_in,
  output logic        enable,
  output logic        start,
  output logic [31:0] cfg,
  output logic        done,
  output logic        ovf,
  output logic [31:0] result
);

  logic clr_done;
  logic clr_ovf;

  assign clr_done = wr_status & wstrb[0] & wdata[ST_DONE];
  assign clr_ovf  = wr_status & wstrb[0] & wdata[ST_OVF];

  always_ff @(posedge clk) begin
    if (rst) begin
      enable <= 1'b0;
      start  <= 1'b0;
      cfg    <= '0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      start <= 1'b0;
      // start only fires when the same write leaves the channel enabled
      if (wr_ctrl && wstrb[0]) begin
        enable <= wdata[CTRL_EN];
        start  <= wdata[CTRL_START] & wdata[CTRL_EN];
      end
      if (wr_cfg) cfg <= apply_strb(cfg, wdata, wstrb);
      // a new done pulse beats a simultaneous clear
      done <= done_in | (done & ~clr_done);
      ovf  <= (done_in & done) | (ovf & ~clr_ovf);
      if (done_in) result <= result_in;
    end
  end

endmodule

// File: rtl/tdc_ctl_axil_regs.sv
// AXI4-Lite control/status slave for NUM_CH TDC channels: handshakes,
// address decode, read mux and interrupt reduction.
module tdc_ctl_axil_regs
  import tdc_ctl_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [ADDR_W-1:0]    s_axi_awaddr,
  input  logic [2:0]           s_axi_awprot,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [DATA_W-1:0]    s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ADDR_W-1:0]    s_axi_araddr,
  input  logic [2:0]           s_axi_arprot,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [DATA_W-1:0]    s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [NUM_CH-1:0]    ch_enable_o,
  output logic [NUM_CH-1:0]    ch_start_o,
  output logic [NUM_CH*32-1:0] ch_cfg_o,
  input  logic [NUM_CH-1:0]    ch_busy_i,
  input  logic [NUM_CH-1:0]    ch_done_i,
  input  logic [NUM_CH*32-1:0] ch_result_i,
  output logic                 irq_o
);

  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    dec_t d;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx;
    d.tgt = TGT_NONE;
    d.ch  = 3'd0;
    d.sel = REG_CTRL;
    off   = a - ADDR_W'(CH_BASE);
    idx   = off >> CH_SHIFT;
    if (a < ADDR_W'(CH_BASE)) begin
      if (a[3:2] == ADDR_ID)          d.tgt = TGT_ID;
      else if (a[3:2] == ADDR_IRQ_EN) d.tgt = TGT_IRQ_EN;
    end else if (idx < ADDR_W'(NUM_CH)) begin
      d.tgt = TGT_CH;
      d.ch  = idx[2:0];
      d.sel = ch_reg_e'(a[3:2]);
    end
    return d;
  endfunction

  logic              wr_rdy;
  logic              wr_fire;
  logic              wr_err;
  logic              wr_ok;
  logic              rd_fire;
  dec_t              wr_dec;
  dec_t              rd_dec;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] done_vec;
  logic [NUM_CH-1:0] ovf_vec;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_cfg;
  logic [NUM_CH-1:0] wr_status;
  logic [NUM_CH-1:0][31:0] result_arr;
  logic              unused;

  assign unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = wr_rdy;
  assign s_axi_wready  = wr_rdy;

  assign wr_fire = wr_rdy & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire = s_axi_arready & s_axi_arvalid;
  assign wr_dec  = decode(s_axi_awaddr);
  assign rd_dec  = decode(s_axi_araddr);
  assign wr_ok   = wr_fire & ~wr_err;

  always_comb begin
    case (wr_dec.tgt)
      TGT_IRQ_EN: wr_err = 1'b0;
      TGT_CH:     wr_err = (wr_dec.sel == REG_RESULT);
      default:    wr_err = 1'b1;
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit          = wr_ok && (wr_dec.tgt == TGT_CH) && (wr_dec.ch == 3'(c));
    assign wr_ctrl[c]   = hit && (wr_dec.sel == REG_CTRL);
    assign wr_cfg[c]    = hit && (wr_dec.sel == REG_CFG);
    assign wr_status[c] = hit && (wr_dec.sel == REG_STATUS);

    tdc_ch_regs u_ch (
      .clk       (ACLK),
      .rst       (ARESET),
      .wr_ctrl   (wr_ctrl[c]),
      .wr_cfg    (wr_cfg[c]),
      .wr_status (wr_status[c]),
      .wdata     (s_axi_wdata),
      .wstrb     (s_axi_wstrb),
      .done_in   (ch_done_i[c]),
      .result_in (ch_result_i[32*c +: 32]),
      .enable    (ch_enable_o[c]),
      .start     (ch_start_o[c]),
      .cfg       (ch_cfg_o[32*c +: 32]),
      .done      (done_vec[c]),
      .ovf       (ovf_vec[c]),
      .result    (result_arr[c])
    );
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_dec.tgt)
      TGT_ID:     rd_data = ID_VALUE;
      TGT_IRQ_EN: rd_data[NUM_CH-1:0] = irq_en;
      TGT_CH: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (rd_dec.ch == 3'(c)) begin
            case (rd_dec.sel)
              REG_CTRL:   rd_data[CTRL_EN] = ch_enable_o[c];
              REG_CFG:    rd_data = ch_cfg_o[32*c +: 32];
              REG_STATUS: begin
                rd_data[ST_BUSY] = ch_busy_i[c];
                rd_data[ST_DONE] = done_vec[c];
                rd_data[ST_OVF]  = ovf_vec[c];
              end
              default:    rd_data = result_arr[c];
            endcase
          end
        end
      end
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_rdy        <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
      irq_en        <= '0;
      irq_o         <= 1'b0;
    end else begin
      // ready is a one-cycle pulse; the !wr_rdy term keeps it from repeating
      wr_rdy <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !wr_rdy;
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      if (wr_ok && (wr_dec.tgt == TGT_IRQ_EN) && s_axi_wstrb[0])
        irq_en <= s_axi_wdata[NUM_CH-1:0];
      irq_o <= |(done_vec & irq_en);
    end
  end

endmodule

// File: tb/tb_tdc_ctl_axil_regs.sv
// Directed bench for tdc_ctl_axil_regs; bus responses are checked by a
// scoreboard monitor, side-band outputs directly by the stimulus.
module tb_tdc_ctl_axil_regs;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 8;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic [ADDR_W-1:0]    s_axi_awaddr;
  logic [2:0]           s_axi_awprot;
  logic                 s_axi_awvalid;
  logic                 s_axi_awready;
  logic [31:0]          s_axi_wdata;
  logic [3:0]           s_axi_wstrb;
  logic                 s_axi_wvalid;
  logic                 s_axi_wready;
  logic [1:0]           s_axi_bresp;
  logic                 s_axi_bvalid;
  logic                 s_axi_bready;
  logic [ADDR_W-1:0]    s_axi_araddr;
  logic [2:0]           s_axi_arprot;
  logic                 s_axi_arvalid;
  logic                 s_axi_arready;
  logic [31:0]          s_axi_rdata;
  logic [1:0]           s_axi_rresp;
  logic                 s_axi_rvalid;
  logic                 s_axi_rready;
  logic [NUM_CH-1:0]    ch_enable_o;
  logic [NUM_CH-1:0]    ch_start_o;
  logic [NUM_CH*32-1:0] ch_cfg_o;
  logic [NUM_CH-1:0]    ch_busy_i;
  logic [NUM_CH-1:0]    ch_done_i;
  logic [NUM_CH*32-1:0] ch_result_i;
  logic                 irq_o;

  tdc_ctl_axil_regs #(.NUM_CH(NUM_CH), .DATA_W(32), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ch_enable_o(ch_enable_o), .ch_start_o(ch_start_o), .ch_cfg_o(ch_cfg_o),
    .ch_busy_i(ch_busy_i), .ch_done_i(ch_done_i), .ch_result_i(ch_result_i),
    .irq_o(irq_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { string name; logic [1:0] resp; } w_exp_t;
  typedef struct { string name; logic [31:0] data; logic [1:0] resp; } r_exp_t;

  w_exp_t wq[$];
  r_exp_t rq[$];
  int checks = 0;
  int passes = 0;
  logic [3:0] start1, start2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    checks++;
    $display("FAIL %s: timeout waiting for DUT handshake", nm);
  endtask

  // scoreboard monitor
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (s_axi_bvalid && s_axi_bready) begin
        if (wq.size() == 0) begin
          checks++;
          $display("FAIL bresp_unexpected: got %h, expected no response", s_axi_bresp);
        end else begin
          w_exp_t we;
          we = wq.pop_front();
          chk({we.name, "_bresp"}, 32'(s_axi_bresp), 32'(we.resp));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (rq.size() == 0) begin
          checks++;
          $display("FAIL rdata_unexpected: got %h, expected no response", s_axi_rdata);
        end else begin
          r_exp_t re;
          re = rq.pop_front();
          chk({re.name, "_rdata"}, s_axi_rdata, re.data);
          chk({re.name, "_rresp"}, 32'(s_axi_rresp), 32'(re.resp));
        end
      end
    end
  end

  task automatic axi_write(input string nm, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp,
                           input bit wait_b = 1'b1, input logic [3:0] done_mask = 4'h0,
                           input logic [31:0] done_res = 32'h0);
    w_exp_t e;
    bit ok;
    e.name = nm;
    e.resp = resp;
    wq.push_back(e);
    @(posedge ACLK); #1;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK); #1;
      if (s_axi_awready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      timeout({nm, "_awready"});
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (done_mask[c]) ch_result_i[32*c +: 32] = done_res;
      ch_done_i = done_mask;
      @(posedge ACLK); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; ch_done_i = '0;
      start1 = ch_start_o;
      if (wait_b) begin
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(posedge ACLK); #1;
          if (i == 0) start2 = ch_start_o;
          if (!s_axi_bvalid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout({nm, "_bvalid"});
      end
    end
  endtask

  task automatic axi_read(input string nm, input logic [7:0] addr,
                          input logic [31:0] data, input logic [1:0] resp);
    r_exp_t e;
    bit ok;
    e.name = nm; e.data = data; e.resp = resp;
    rq.push_back(e);
    @(posedge ACLK); #1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK); #1;
      if (s_axi_arready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      timeout({nm, "_arready"});
      s_axi_arvalid = 1'b0;
    end else begin
      @(posedge ACLK); #1;
      s_axi_arvalid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(posedge ACLK); #1;
        if (!s_axi_rvalid) begin ok = 1'b1; break; end
      end
      if (!ok) timeout({nm, "_rvalid"});
    end
  endtask

  task automatic pulse_done(input int ch, input logic [31:0] val);
    @(posedge ACLK); #1;
    ch_result_i[32*ch +: 32] = val;
    ch_done_i[ch] = 1'b1;
    @(posedge ACLK); #1;
    ch_done_i = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_bv, bad_aw;
    bit ok;
    ARESET = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    ch_busy_i = '0; ch_done_i = '0; ch_result_i = '0;
    start1 = '0; start2 = '0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    chk("rst_ready", {30'b0, s_axi_awready, s_axi_arready}, 32'h0);
    chk("rst_valid", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
    chk("rst_rdata", s_axi_rdata, 32'h0);
    chk("rst_chout", {24'b0, ch_enable_o, ch_start_o}, 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);

    axi_read("rd_id", 8'h00, 32'h7DC0_0100, OK);
    axi_read("rd_cfg0_rst", 8'h14, 32'h0, OK);
    axi_read("rd_unmapped08", 8'h08, 32'h0, ERR);
    axi_read("rd_unmapped0c", 8'h0C, 32'h0, ERR);
    axi_read("rd_ch4_oor", 8'h50, 32'h0, ERR);

    axi_write("wr_cfg0_strb3", 8'h14, 32'hA5A5_A5A5, 4'h3, OK);
    axi_read("rd_cfg0_a", 8'h14, 32'h0000_A5A5, OK);
    chk("cfg_o0_a", ch_cfg_o[31:0], 32'h0000_A5A5);
    axi_write("wr_cfg0_full", 8'h14, 32'h1234_5678, 4'hF, OK);
    axi_read("rd_cfg0_b", 8'h14, 32'h1234_5678, OK);
    chk("cfg_o0_b", ch_cfg_o[31:0], 32'h1234_5678);

    axi_write("wr_id_ro", 8'h00, 32'h0, 4'hF, ERR);
    axi_write("wr_result_ro", 8'h1C, 32'hFFFF_FFFF, 4'hF, ERR);
    axi_write("wr_ch4_oor", 8'h54, 32'hFFFF_FFFF, 4'hF, ERR);
    axi_read("rd_id_again", 8'h00, 32'h7DC0_0100, OK);
    axi_read("rd_result0_ro", 8'h1C, 32'h0, OK);

    axi_write("wr_start1", 8'h20, 32'h3, 4'hF, OK);
    chk("start1_pulse", 32'(start1), 32'h2);
    chk("start1_gone", 32'(start2), 32'h0);
    chk("enable_after_start", 32'(ch_enable_o), 32'h2);
    axi_read("rd_ctrl1", 8'h20, 32'h1, OK);
    axi_write("wr_start2_dis", 8'h30, 32'h2, 4'hF, OK);
    chk("start2_none_a", 32'(start1), 32'h0);
    chk("start2_none_b", 32'(start2), 32'h0);
    axi_write("wr_ctrl1_nolane0", 8'h20, 32'h0, 4'h2, OK);
    axi_read("rd_ctrl1_kept", 8'h20, 32'h1, OK);
    chk("enable_kept", 32'(ch_enable_o), 32'h2);

    pulse_done(2, 32'hDEAD_0001);
    axi_read("rd_st2_a", 8'h38, 32'h2, OK);
    axi_read("rd_res2_a", 8'h3C, 32'hDEAD_0001, OK);
    chk("irq_masked", 32'(irq_o), 32'h0);
    pulse_done(2, 32'hDEAD_0002);
    ch_busy_i = 4'b0100;
    axi_read("rd_st2_b", 8'h38, 32'h7, OK);
    ch_busy_i = '0;
    axi_read("rd_res2_b", 8'h3C, 32'hDEAD_0002, OK);
    axi_write("wr_st2_w1c", 8'h38, 32'h6, 4'hF, OK);
    axi_read("rd_st2_c", 8'h38, 32'h0, OK);
    axi_read("rd_res2_c", 8'h3C, 32'hDEAD_0002, OK);

    axi_write("wr_irqen_all", 8'h04, 32'hFFFF_FFFF, 4'hF, OK);
    axi_read("rd_irqen_all", 8'h04, 32'h0000_000F, OK);
    axi_write("wr_irqen_1", 8'h04, 32'h1, 4'hF, OK);
    pulse_done(0, 32'h0000_0011);
    repeat (2) @(posedge ACLK);
    #1 chk("irq_set", 32'(irq_o), 32'h1);
    axi_write("wr_w1c_race", 8'h18, 32'h2, 4'hF, OK, 1'b1, 4'b0001, 32'h0000_0022);
    chk("irq_race_a", 32'(irq_o), 32'h1);
    @(posedge ACLK); #1 chk("irq_race_b", 32'(irq_o), 32'h1);
    axi_read("rd_st0_race", 8'h18, 32'h6, OK);
    axi_read("rd_res0_race", 8'h1C, 32'h0000_0022, OK);
    axi_write("wr_st0_clr", 8'h18, 32'h6, 4'hF, OK);
    axi_read("rd_st0_clr", 8'h18, 32'h0, OK);
    chk("irq_clear", 32'(irq_o), 32'h0);

    s_axi_bready = 1'b0;
    axi_write("wr_hold1", 8'h14, 32'h1111_2222, 4'hF, OK, 1'b0);
    s_axi_awaddr = 8'h24; s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    bad_bv = 0; bad_aw = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      if (!s_axi_bvalid) bad_bv++;
      if (s_axi_awready) bad_aw++;
    end
    chk("hold_bvalid_drop_cycles", bad_bv, 0);
    chk("hold_awready_cycles", bad_aw, 0);
    s_axi_bready = 1'b1;
    axi_write("wr_hold2", 8'h24, 32'h0BAD_F00D, 4'hF, OK);
    axi_read("rd_hold1", 8'h14, 32'h1111_2222, OK);
    axi_read("rd_hold2", 8'h24, 32'h0BAD_F00D, OK);

    axi_write("wr_irqen_pre", 8'h04, 32'h4, 4'hF, OK);
    pulse_done(2, 32'hCAFE_0003);
    @(posedge ACLK); #1;
    s_axi_araddr = 8'h00; s_axi_arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK); #1;
      if (s_axi_arready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("rst_mid_arready");
    ARESET = 1'b1; s_axi_arvalid = 1'b0;
    @(posedge ACLK); #1;
    chk("rst_mid_rvalid", 32'(s_axi_rvalid), 32'h0);
    @(posedge ACLK); #1;
    chk("rst_mid_rvalid2", 32'(s_axi_rvalid), 32'h0);
    chk("rst_mid_enable", 32'(ch_enable_o), 32'h0);
    chk("rst_mid_cfg", (ch_cfg_o == '0) ? 32'h1 : 32'h0, 32'h1);
    chk("rst_mid_irq", 32'(irq_o), 32'h0);
    ARESET = 1'b0;
    axi_read("post_rst_irqen", 8'h04, 32'h0, OK);
    axi_read("post_rst_cfg0", 8'h14, 32'h0, OK);
    axi_read("post_rst_cfg1", 8'h24, 32'h0, OK);
    axi_read("post_rst_ctrl1", 8'h20, 32'h0, OK);
    axi_read("post_rst_st2", 8'h38, 32'h0, OK);
    axi_read("post_rst_res2", 8'h3C, 32'h0, OK);

    repeat (5) @(posedge ACLK);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
